// File: rtl/product_packer.sv
// product_packer: latches k operand pairs, multiplies them one at a time
// with a single shift-add unit (one bit of b per cycle, LSB first), packs
// the (m+n)-bit products into dout and holds them with pl=1 until the
// accumulator signals acc_ready.
// Optional feature: define ZERO_SKIP_EN to finish a product in one cycle
// when either of its operands is zero.
module product_packer #(
  parameter int m = 4,
  parameter int n = 4,
  parameter int k = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [k*m-1:0]       a,
  input  logic [k*n-1:0]       b,
  output logic                 busy,
  output logic                 pl,
  output logic [k*(m+n)-1:0]   dout,
  input  logic                 acc_ready
);

  localparam int P  = m + n;
  localparam int IW = (k > 1) ? $clog2(k) : 1;
  localparam int CW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, MUL, LOAD} state_e;

  state_e           state_q;
  logic [k*m-1:0]   a_q;
  logic [k*n-1:0]   b_q;
  logic [IW-1:0]    idx_q;
  logic [CW-1:0]    bitcnt_q;
  logic [P-1:0]     pp_q;
  logic [P-1:0]     pp_d;
  logic [k*P-1:0]   dout_q;
  logic             busy_q;
  logic             pl_q;
  logic             load_first_q;

  logic [m-1:0]     a_cur;
  logic [n-1:0]     b_cur;
  logic             last_bit;
  logic             last_slot;
  logic             skip;

  // Select the current operand pair and form the next partial product.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    skip      = 1'b0;
    a_cur     = a_q[idx_q*m +: m];
    b_cur     = b_q[idx_q*n +: n];
    last_bit  = (bitcnt_q == CW'(n - 1));
    last_slot = (idx_q == IW'(k - 1));
    pp_d      = pp_q;
    if (b_cur[bitcnt_q]) begin
      pp_d = pp_q + (P'(a_cur) << bitcnt_q);
    end
`ifdef ZERO_SKIP_EN
    skip = (bitcnt_q == '0) && ((a_cur == '0) || (b_cur == '0));
`else
    skip = 1'b0;
`endif
  end

  // Operand capture at job start; later changes on a/b do not affect the job.
  always_ff @(posedge clk) begin
    // NOTE: the operand registers carry no reset; they are always reloaded
    // before use, so resetting them would only add reset fan-out.
    if (!rst && state_q == IDLE && start) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Control FSM with shift-add datapath and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q      <= IDLE;
      busy_q       <= 1'b0;
      pl_q         <= 1'b0;
      dout_q       <= '0;
      idx_q        <= '0;
      bitcnt_q     <= '0;
      pp_q         <= '0;
      load_first_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            idx_q    <= '0;
            bitcnt_q <= '0;
            pp_q     <= '0;
            busy_q   <= 1'b1;
            state_q  <= MUL;
          end
        end
        MUL: begin
          if (skip || last_bit) begin
            dout_q[idx_q*P +: P] <= skip ? '0 : pp_d;
            pp_q     <= '0;
            bitcnt_q <= '0;
            if (last_slot) begin
              state_q      <= LOAD;
              pl_q         <= 1'b1;
              load_first_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end else begin
            pp_q     <= pp_d;
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end
        LOAD: begin
          // The first LOAD cycle ignores acc_ready to reject a stale ready.
          if (load_first_q) begin
            load_first_q <= 1'b0;
          end else if (acc_ready) begin
            state_q <= IDLE;
            pl_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          pl_q    <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign pl   = pl_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_product_packer.sv
// Self-checking bench for product_packer: directed scenarios plus random
// jobs, compared against a product/latency model computed with plain
// arithmetic from the operand vectors.
module tb_product_packer;

  localparam int M = 4;
  localparam int N = 4;
  localparam int K = 10;
  localparam int P = M + N;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [K*M-1:0]   a;
  logic [K*N-1:0]   b;
  logic             busy;
  logic             pl;
  logic [K*P-1:0]   dout;
  logic             acc_ready;

  int total_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  product_packer #(.m(M), .n(N), .k(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .pl        (pl),
    .dout      (dout),
    .acc_ready (acc_ready)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected cycles from start edge to pl rising.
  function automatic int exp_latency(input logic [K*M-1:0] av, input logic [K*N-1:0] bv);
    int lat = 0;
    for (int j = 0; j < K; j++) begin
`ifdef ZERO_SKIP_EN
      lat += ((av[j*M +: M] == 0) || (bv[j*N +: N] == 0)) ? 1 : N;
`else
      lat += N;
`endif
    end
    return lat;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_pl", pl, 0);
    check("rst_dout", dout, 0);
    rst = 1'b0;
  endtask

  // Runs one job; d = LOAD cycles before acc_ready is raised.
  // keep_start leaves start high through the job and after it.
  task automatic run_job(input string tag, input logic [K*M-1:0] av,
                         input logic [K*N-1:0] bv, input int d, input bit keep_start);
    logic [K*P-1:0] exp_d;
    int sum = 0;
    int dsum = 0;
    int cnt = 0;
    int hi = 1;
    int i = 0;
    int exp_hi;
    for (int j = 0; j < K; j++) begin
      int pr;
      pr = int'(av[j*M +: M]) * int'(bv[j*N +: N]);
      exp_d[j*P +: P] = P'(pr);
      sum += pr;
    end
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!keep_start) start = 1'b0;
    a = ~av;
    b = ~bv;
    check({tag, "_busy"}, busy, 1);
    while (!pl && cnt < 300) begin
      acc_ready = 1'($urandom);
      @(posedge clk);
      #1;
      cnt++;
    end
    if (!pl) begin
      check({tag, "_pl_timeout"}, pl, 1);
      do_reset();
      return;
    end
    check({tag, "_latency"}, cnt, exp_latency(av, bv));
    for (int j = 0; j < K; j++) begin
      check($sformatf("%s_p%0d", tag, j), dout[j*P +: P], exp_d[j*P +: P]);
      dsum += int'(dout[j*P +: P]);
    end
    check({tag, "_sum"}, dsum, sum);
    while (pl && hi < 100) begin
      acc_ready = (i >= d);
      @(posedge clk);
      #1;
      i++;
      if (pl) begin
        hi++;
        check({tag, "_frozen"}, dout, exp_d);
      end
    end
    acc_ready = 1'b0;
    exp_hi = (d + 1 > 2) ? d + 1 : 2;
    check({tag, "_pl_cycles"}, hi, exp_hi);
    check({tag, "_idle_busy"}, busy, 0);
  endtask

  initial begin
    logic [K*M-1:0] av;
    logic [K*N-1:0] bv;
    logic [63:0]    r;

    a = '0;
    b = '0;
    do_reset();

    // Reset in the middle of MUL aborts the job.
    a = '1;
    b = '1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pl", pl, 0);
    r = {$urandom, $urandom};
    run_job("clean", r[K*M-1:0], ~r[K*N-1:0], 1, 1'b0);

    // All-ones operands.
    run_job("max", '1, '1, int'($urandom_range(0, 3)), 1'b0);

    // a_j = j, b_j = j+1, ready held high -> two pl cycles.
    for (int j = 0; j < K; j++) begin
      av[j*M +: M] = M'(j);
      bv[j*N +: N] = N'(j + 1);
    end
    run_job("ramp", av, bv, 0, 1'b0);

    // start held high: one job, then a fresh job from IDLE with new operands.
    r = {$urandom, $urandom};
    run_job("hold1", r[K*M-1:0], r[63:64-K*N], 2, 1'b1);
    r = {$urandom, $urandom};
    run_job("hold2", r[K*M-1:0], r[63:64-K*N], 0, 1'b0);

    // Long acc_ready stall.
    r = {$urandom, $urandom};
    run_job("stall", r[K*M-1:0], r[63:64-K*N], 20, 1'b0);

    // Zero operands in the first five slots.
    for (int j = 0; j < K; j++) begin
      av[j*M +: M] = (j < 5) ? M'(0) : M'(3);
      bv[j*N +: N] = N'(5);
    end
    run_job("zero", av, bv, 1, 1'b0);

    // Random jobs.
    for (int t = 0; t < 100; t++) begin
      r = {$urandom, $urandom};
      av = r[K*M-1:0];
      r = {$urandom, $urandom};
      bv = r[K*N-1:0];
      run_job($sformatf("rnd%0d", t), av, bv, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
